// File: rtl/fetch_unit.sv
// Instruction fetch initiator: owns the PC, drives a combinational imem read port
// and buffers fetched {pc, instr} pairs in a DEPTH-entry FIFO toward decode.
// Latency: fetch in cycle N is visible on out_* in N+1 (registered outputs).
// Backpressure: when the FIFO is full and decode stalls, the PC holds; a pop frees a slot for a same-cycle push.
//
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   imem_*              - instruction memory port (read only; address = PC register)
//   redirect_valid/_pc  - branch/jump redirect from execute; flushes FIFO, reloads PC
//   out_valid/_ready    - valid/ready handshake toward decode
//   out_pc/out_instr    - head entry of the FIFO
module fetch_unit #(
  parameter int                   ADDRWIDTH  = 32,
  parameter int                   DATAWIDTH  = 32,
  parameter logic [ADDRWIDTH-1:0] START_ADDR = 32'h01000000,
  parameter int                   DEPTH      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [ADDRWIDTH-1:0] imem_address,
  output logic                 imem_read_write,
  output logic [DATAWIDTH-1:0] imem_data_in,
  input  logic [DATAWIDTH-1:0] imem_data_out,
  input  logic                 redirect_valid,
  input  logic [ADDRWIDTH-1:0] redirect_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDRWIDTH-1:0] out_pc,
  output logic [DATAWIDTH-1:0] out_instr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDRWIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [ADDRWIDTH-1:0] pc_mem_q    [DEPTH];
  logic [DATAWIDTH-1:0] instr_mem_q [DEPTH];

  logic push;
  logic pop;

  // Memory is never written by fetch.
  assign imem_read_write = 1'b0;
  assign imem_data_in    = '0;
  assign imem_address    = pc_q;

  // All decode-facing outputs come straight from registers.
  assign out_valid = (count_q != '0);
  assign out_pc    = pc_mem_q[rd_ptr_q];
  assign out_instr = instr_mem_q[rd_ptr_q];

  // A handshake coinciding with a redirect is not a transfer: the flush wins.
  assign pop  = out_valid & out_ready & ~redirect_valid;
  // A pop frees a slot, so a full FIFO can still accept in the same cycle.
  assign push = ~redirect_valid & ((count_q < CW'(DEPTH)) | pop);

  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      // Low address bits are forced to zero (word-aligned fetch).
      pc_d     = redirect_pc & ~ADDRWIDTH'(3);
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + ADDRWIDTH'(4);
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= START_ADDR;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so out_pc/out_instr read as zero until the first fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]    <= pc_q;
      instr_mem_q[wr_ptr_q] <= imem_data_out;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] START = 32'h01000000;

  logic        clk;
  logic        reset;
  logic [31:0] imem_address;
  logic        imem_read_write;
  logic [31:0] imem_data_in;
  logic [31:0] imem_data_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int total = 0;
  int bad   = 0;

  fetch_unit #(
    .ADDRWIDTH (32),
    .DATAWIDTH (32),
    .START_ADDR(START),
    .DEPTH     (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_address   (imem_address),
    .imem_read_write(imem_read_write),
    .imem_data_in   (imem_data_in),
    .imem_data_out  (imem_data_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: two fixed words, a scrambled function of the address elsewhere.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h01000000) return 32'h00940333;
    if (a == 32'h01000004) return 32'h413903b3;
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  assign imem_data_out = mem_fn(imem_address);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of fetched entries plus the next fetch address.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] mpc;
  bit          model_known = 0;

  task automatic drive_and_check(input logic rst, input logic rv, input logic [31:0] rpc,
                                 input logic rdy);
    @(negedge clk);
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    check("rw_zero", {31'b0, imem_read_write}, 32'h0);
    check("din_zero", imem_data_in, 32'h0);
    if (model_known) begin
      check("m_addr", imem_address, mpc);
      check("m_vld", {31'b0, out_valid}, {31'b0, (mq.size() > 0)});
      if (mq.size() > 0) begin
        check("m_pc", out_pc, mq[0].pc);
        check("m_instr", out_instr, mq[0].instr);
      end
    end
  endtask

  task automatic advance();
    entry_t e;
    @(posedge clk);
    model_known = 1;
    if (reset) begin
      mq.delete();
      mpc = START;
    end else if (redirect_valid) begin
      mq.delete();
      mpc = redirect_pc & ~32'h3;
    end else begin
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (mq.size() < DEPTH) begin
        e.pc    = mpc;
        e.instr = mem_fn(mpc);
        mq.push_back(e);
        mpc = mpc + 32'd4;
      end
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_vld;
    logic        chk_dat;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_addr;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic rv, input logic [31:0] rpc,
                              input logic rdy, input logic e_vld, input logic chk_dat,
                              input logic [31:0] e_pc, input logic [31:0] e_instr,
                              input logic [31:0] e_addr);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.e_vld = e_vld; v.chk_dat = chk_dat;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_addr = e_addr;
    return v;
  endfunction

  vec_t tv[28];

  initial begin
    // Each vector: inputs applied during a cycle and the outputs expected in that same cycle.
    //            rst rv rpc           rdy vld dat e_pc          e_instr                    e_addr
    tv[0]  = mk(1, 0, 32'h0,        0, 0, 1, 32'h0,        32'h0,                     START);
    tv[1]  = mk(1, 0, 32'h0,        0, 0, 1, 32'h0,        32'h0,                     START);
    tv[2]  = mk(0, 0, 32'h0,        1, 0, 1, 32'h0,        32'h0,                     START);
    tv[3]  = mk(0, 0, 32'h0,        1, 1, 1, 32'h01000000, 32'h00940333,              32'h01000004);
    tv[4]  = mk(1, 0, 32'h0,        1, 1, 1, 32'h01000004, 32'h413903b3,              32'h01000008);
    tv[5]  = mk(0, 0, 32'h0,        0, 0, 1, 32'h0,        32'h0,                     START);
    tv[6]  = mk(0, 0, 32'h0,        0, 1, 1, 32'h01000000, 32'h00940333,              32'h01000004);
    tv[7]  = mk(0, 0, 32'h0,        0, 1, 1, 32'h01000000, 32'h00940333,              32'h01000008);
    tv[8]  = mk(0, 0, 32'h0,        0, 1, 1, 32'h01000000, 32'h00940333,              32'h01000008);
    tv[9]  = mk(0, 0, 32'h0,        0, 1, 1, 32'h01000000, 32'h00940333,              32'h01000008);
    tv[10] = mk(0, 0, 32'h0,        1, 1, 1, 32'h01000000, 32'h00940333,              32'h01000008);
    tv[11] = mk(0, 0, 32'h0,        1, 1, 1, 32'h01000004, 32'h413903b3,              32'h0100000C);
    tv[12] = mk(0, 0, 32'h0,        0, 1, 1, 32'h01000008, mem_fn(32'h01000008),      32'h01000010);
    tv[13] = mk(0, 0, 32'h0,        1, 1, 1, 32'h01000008, mem_fn(32'h01000008),      32'h01000010);
    tv[14] = mk(0, 0, 32'h0,        1, 1, 1, 32'h0100000C, mem_fn(32'h0100000C),      32'h01000014);
    tv[15] = mk(0, 1, 32'h01000043, 1, 1, 1, 32'h01000010, mem_fn(32'h01000010),      32'h01000018);
    tv[16] = mk(0, 0, 32'h0,        1, 0, 0, 32'h0,        32'h0,                     32'h01000040);
    tv[17] = mk(0, 0, 32'h0,        1, 1, 1, 32'h01000040, mem_fn(32'h01000040),      32'h01000044);
    tv[18] = mk(0, 0, 32'h0,        0, 1, 1, 32'h01000044, mem_fn(32'h01000044),      32'h01000048);
    tv[19] = mk(0, 1, 32'h01000100, 0, 1, 1, 32'h01000044, mem_fn(32'h01000044),      32'h0100004C);
    tv[20] = mk(0, 1, 32'h01000200, 1, 0, 0, 32'h0,        32'h0,                     32'h01000100);
    tv[21] = mk(0, 0, 32'h0,        1, 0, 0, 32'h0,        32'h0,                     32'h01000200);
    tv[22] = mk(0, 0, 32'h0,        1, 1, 1, 32'h01000200, mem_fn(32'h01000200),      32'h01000204);
    tv[23] = mk(0, 1, 32'hFFFFFFFE, 1, 1, 1, 32'h01000204, mem_fn(32'h01000204),      32'h01000208);
    tv[24] = mk(0, 0, 32'h0,        1, 0, 0, 32'h0,        32'h0,                     32'hFFFFFFFC);
    tv[25] = mk(0, 0, 32'h0,        1, 1, 1, 32'hFFFFFFFC, mem_fn(32'hFFFFFFFC),      32'h00000000);
    tv[26] = mk(1, 0, 32'h0,        1, 1, 1, 32'h00000000, mem_fn(32'h00000000),      32'h00000004);
    tv[27] = mk(0, 0, 32'h0,        1, 0, 1, 32'h0,        32'h0,                     START);

    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    // One reset edge before any comparison so the DUT state is defined.
    advance();

    for (int i = 0; i < 28; i++) begin
      drive_and_check(tv[i].rst, tv[i].rv, tv[i].rpc, tv[i].rdy);
      check($sformatf("v%0d_addr", i), imem_address, tv[i].e_addr);
      check($sformatf("v%0d_vld", i), {31'b0, out_valid}, {31'b0, tv[i].e_vld});
      if (tv[i].chk_dat) begin
        check($sformatf("v%0d_pc", i), out_pc, tv[i].e_pc);
        check($sformatf("v%0d_instr", i), out_instr, tv[i].e_instr);
      end
      advance();
    end

    // Randomised traffic against the queue model.
    for (int c = 0; c < 800; c++) begin
      logic        r_rst;
      logic        r_rv;
      logic [31:0] r_pc;
      logic        r_rdy;
      r_rst = ($urandom_range(0, 59) == 0);
      r_rv  = ($urandom_range(0, 7) == 0);
      r_pc  = $urandom();
      if ($urandom_range(0, 3) == 0) r_pc = 32'hFFFFFFF0 | {28'b0, r_pc[3:0]};
      r_rdy = ($urandom_range(0, 2) != 0);
      drive_and_check(r_rst, r_rv, r_pc, r_rdy);
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
